// File: rtl/vtx_trace_capture.sv
// vtx_trace_capture: assembles one trace record per retired coprocessor instruction
// (operands, result, memory transactions, CPR snapshots) and emits it with a vtx_valid pulse.
`default_nettype none

module vtx_trace_capture #(
   parameter int MEM_TXNS = 4,
   parameter int NCPRS    = 16
) (
   input  logic                      g_clk,
   input  logic                      g_resetn,
   input  logic                      cpu_insn_req,
   input  logic                      cpu_insn_ack,
   input  logic [31:0]               cpu_insn_enc,
   input  logic [31:0]               cpu_rs1,
   input  logic [31:0]               cpu_rs2,
   input  logic                      cop_insn_rsp,
   input  logic                      cop_insn_ack,
   input  logic [2:0]                cop_result,
   input  logic [31:0]               cop_wdata,
   input  logic [4:0]                cop_waddr,
   input  logic                      cop_wen,
   input  logic                      mem_cen,
   input  logic                      mem_wen,
   input  logic                      mem_stall,
   input  logic [31:0]               mem_addr,
   input  logic [31:0]               mem_wdata,
   input  logic [3:0]                mem_ben,
   input  logic [31:0]               mem_rdata,
   input  logic                      mem_error,
   input  logic [32*NCPRS-1:0]       cprs_flat,
   input  logic [31:0]               rng_sample,
   output logic                      vtx_reset,
   output logic                      vtx_valid,
   output logic [31:0]               vtx_instr_enc,
   output logic [31:0]               vtx_instr_rs1,
   output logic [31:0]               vtx_instr_rs2,
   output logic [31:0]               vtx_instr_wdata,
   output logic [31:0]               vtx_rand_sample,
   output logic [2:0]                vtx_instr_result,
   output logic [4:0]                vtx_instr_waddr,
   output logic                      vtx_instr_wen,
   output logic [MEM_TXNS-1:0]       vtx_mem_cen,
   output logic [MEM_TXNS-1:0]       vtx_mem_wen,
   output logic [MEM_TXNS-1:0]       vtx_mem_error,
   output logic [4*MEM_TXNS-1:0]     vtx_mem_ben,
   output logic [32*MEM_TXNS-1:0]    vtx_mem_addr,
   output logic [32*MEM_TXNS-1:0]    vtx_mem_wdata,
   output logic [32*MEM_TXNS-1:0]    vtx_mem_rdata,
   output logic [32*NCPRS-1:0]       vtx_cprs_pre,
   output logic [32*NCPRS-1:0]       vtx_cprs_post,
   output logic                      vtx_mem_overflow
);

   localparam int CW = $clog2(MEM_TXNS + 1);
   localparam int SW = (MEM_TXNS > 1) ? $clog2(MEM_TXNS) : 1;
   localparam logic [CW-1:0] C_FULL = CW'(MEM_TXNS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_POST = 2'd2,
      S_EMIT = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [31:0]          enc_q, rs1_q, rs2_q, wdata_q, rand_q;
   logic [2:0]           result_q;
   logic [4:0]           waddr_q;
   logic                 wen_q, ovf_q, reset_q, pend_q;
   logic [MEM_TXNS-1:0]  m_cen_q, m_wen_q, m_err_q;
   logic [3:0]           m_ben_q   [MEM_TXNS];
   logic [31:0]          m_addr_q  [MEM_TXNS];
   logic [31:0]          m_wdata_q [MEM_TXNS];
   logic [31:0]          m_rdata_q [MEM_TXNS];
   logic [32*NCPRS-1:0]  pre_q, post_q;
   logic [SW-1:0]        pend_idx_q;
   logic [CW-1:0]        count_q;

   logic accept, respond, mtxn, capture_new, capture_rsp, rec_mtxn;

   assign accept   = cpu_insn_req & cpu_insn_ack;
   assign respond  = cop_insn_rsp & cop_insn_ack;
   assign mtxn     = mem_cen & ~mem_stall;
   assign rec_mtxn = (state_q == S_BUSY) & mtxn;

   always_comb begin
      state_d     = state_q;
      capture_new = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               capture_new = 1'b1;
               state_d     = respond ? S_POST : S_BUSY;
            end
         end
         S_BUSY: begin
            if (respond) state_d = S_POST;
         end
         S_POST: state_d = S_EMIT;
         S_EMIT: begin
            if (accept) begin
               capture_new = 1'b1;
               state_d     = respond ? S_POST : S_BUSY;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      capture_rsp = respond & ((state_q == S_BUSY) | capture_new);
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state_q    <= S_IDLE;
         reset_q    <= 1'b1;
         enc_q      <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         wdata_q    <= '0;
         rand_q     <= '0;
         result_q   <= '0;
         waddr_q    <= '0;
         wen_q      <= 1'b0;
         ovf_q      <= 1'b0;
         pend_q     <= 1'b0;
         pend_idx_q <= '0;
         count_q    <= '0;
         m_cen_q    <= '0;
         m_wen_q    <= '0;
         m_err_q    <= '0;
         pre_q      <= '0;
         post_q     <= '0;
         for (int i = 0; i < MEM_TXNS; i++) begin
            m_ben_q[i]   <= '0;
            m_addr_q[i]  <= '0;
            m_wdata_q[i] <= '0;
            m_rdata_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         reset_q <= 1'b0;
         pend_q  <= rec_mtxn & (count_q != C_FULL);

         if (capture_new) begin
            enc_q   <= cpu_insn_enc;
            rs1_q   <= cpu_rs1;
            rs2_q   <= cpu_rs2;
            rand_q  <= rng_sample;
            pre_q   <= cprs_flat;
            m_cen_q <= '0;
            m_wen_q <= '0;
            m_err_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
         end

         if (capture_rsp) begin
            result_q <= cop_result;
            wdata_q  <= cop_wdata;
            waddr_q  <= cop_waddr;
            wen_q    <= cop_wen;
         end

         if (rec_mtxn) begin
            if (count_q != C_FULL) begin
               m_cen_q[count_q[SW-1:0]]   <= 1'b1;
               m_wen_q[count_q[SW-1:0]]   <= mem_wen;
               m_addr_q[count_q[SW-1:0]]  <= mem_addr;
               m_wdata_q[count_q[SW-1:0]] <= mem_wdata;
               m_ben_q[count_q[SW-1:0]]   <= mem_ben;
               pend_idx_q                 <= count_q[SW-1:0];
               count_q                    <= count_q + CW'(1);
            end else begin
               ovf_q <= 1'b1;
            end
         end

         // Response data trails acceptance by one cycle and may land in POST.
         if (pend_q) begin
            m_rdata_q[pend_idx_q] <= mem_rdata;
            m_err_q[pend_idx_q]   <= mem_error;
         end

         if (state_q == S_POST) post_q <= cprs_flat;
      end
   end

   for (genvar i = 0; i < MEM_TXNS; i++) begin : g_slot
      assign vtx_mem_ben[4*i +: 4]    = m_ben_q[i];
      assign vtx_mem_addr[32*i +: 32]  = m_addr_q[i];
      assign vtx_mem_wdata[32*i +: 32] = m_wdata_q[i];
      assign vtx_mem_rdata[32*i +: 32] = m_rdata_q[i];
   end

   assign vtx_reset        = reset_q;
   assign vtx_valid        = (state_q == S_EMIT);
   assign vtx_instr_enc    = enc_q;
   assign vtx_instr_rs1    = rs1_q;
   assign vtx_instr_rs2    = rs2_q;
   assign vtx_instr_wdata  = wdata_q;
   assign vtx_rand_sample  = rand_q;
   assign vtx_instr_result = result_q;
   assign vtx_instr_waddr  = waddr_q;
   assign vtx_instr_wen    = wen_q;
   assign vtx_mem_cen      = m_cen_q;
   assign vtx_mem_wen      = m_wen_q;
   assign vtx_mem_error    = m_err_q;
   assign vtx_cprs_pre     = pre_q;
   assign vtx_cprs_post    = post_q;
   assign vtx_mem_overflow = ovf_q;

endmodule

`default_nettype wire
